// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: size codes and FSM states shared by the memory access stage
package mem_access_unit_pkg;
    typedef enum logic [1:0] {
        SZ_WORD = 2'd0,
        SZ_HALF = 2'd1,
        SZ_BYTE = 2'd2,
        SZ_ILL  = 2'd3
    } size_e;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: word-wide data bus with byte enables and req/ack handshake
interface mem_access_unit_if;
    logic        busReq;
    logic        busWe;
    logic [31:0] busAddr;
    logic [3:0]  busBe;
    logic [31:0] busWData;
    logic [31:0] busRData;
    logic        busAck;
    modport master (output busReq, busWe, busAddr, busBe, busWData, input busRData, busAck);
    modport slave  (input busReq, busWe, busAddr, busBe, busWData, output busRData, busAck);
endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte enables, store lane replication and load extract/extend
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  size_e       i_size,
    input  logic        i_ext,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ldata
);
    logic [31:0] w_sh;
    // Halves are always 2-aligned, so one byte-granular shift serves both sizes
    assign w_sh    = i_rdata >> {i_off, 3'b000};
    assign o_be    = i_size == SZ_WORD ? 4'b1111 :
                     i_size == SZ_HALF ? (i_off[1] ? 4'b1100 : 4'b0011) :
                     4'b0001 << i_off;
    assign o_wdata = i_size == SZ_BYTE ? {4{i_wdata[7:0]}} :
                     i_size == SZ_HALF ? {2{i_wdata[15:0]}} : i_wdata;
    // ext = 0 sign-extends, ext = 1 zero-extends
    assign o_ldata = i_size == SZ_BYTE ? {{24{~i_ext & w_sh[7]}}, w_sh[7:0]} :
                     i_size == SZ_HALF ? {{16{~i_ext & w_sh[15]}}, w_sh[15:0]} : i_rdata;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: data-memory access stage with bus handshake, stall and error flags
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [1:0]  memDataSize,
    input  logic        memBitExt,
    input  logic [31:0] addr,
    input  logic [31:0] storeData,
    output logic        stall,
    output logic [31:0] loadData,
    output logic        accErr,
    output logic        busErr,
    mem_access_unit_if.master bus
);
    state_e      r_state, w_next;
    logic [CNT_W-1:0] r_cnt;
    logic        r_wr, r_ext, r_req, r_we, r_err;
    size_e       r_size, w_size;
    logic [1:0]  r_off, w_off;
    logic        w_ext, w_req, w_err, w_timeout;
    logic [31:0] r_load, r_addr, r_wdata, w_wdata, w_ldata;
    logic [3:0]  r_be, w_be;

    assign w_req     = memRead | memWrite;
    assign w_err     = (memRead & memWrite) || memDataSize == SZ_ILL ||
                       (memDataSize == SZ_HALF && addr[0]) || (memDataSize == SZ_WORD && addr[1:0] != 2'b00);
    assign w_timeout = r_cnt == CNT_W'(TIMEOUT - 1);
    // The aligner sees live inputs while launching and the latched access afterwards
    assign w_size    = r_state == IDLE ? size_e'(memDataSize) : r_size;
    assign w_ext     = r_state == IDLE ? memBitExt : r_ext;
    assign w_off     = r_state == IDLE ? addr[1:0] : r_off;

    mem_lane_align u_align (
        .i_size  (w_size),
        .i_ext   (w_ext),
        .i_off   (w_off),
        .i_wdata (storeData),
        .i_rdata (bus.busRData),
        .o_be    (w_be),
        .o_wdata (w_wdata),
        .o_ldata (w_ldata)
    );

    assign loadData     = r_load;
    assign busErr       = r_err;
    assign bus.busReq   = r_req;
    assign bus.busWe    = r_we;
    assign bus.busAddr  = r_addr;
    assign bus.busBe    = r_be;
    assign bus.busWData = r_wdata;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next state plus the combinational stall / access-error outputs
    always_comb begin
        w_next = r_state;
        stall  = 1'b0;
        accErr = 1'b0;
        case (r_state)
            IDLE: begin
                stall  = w_req & ~w_err;
                accErr = w_req & w_err;
                w_next = (w_req & ~w_err) ? REQ : IDLE;
            end
            REQ: begin
                stall  = 1'b1;
                w_next = (bus.busAck | w_timeout) ? DONE : REQ;
            end
            default: w_next = IDLE;
        endcase
    end

    // Bus launch, completion capture, timeout counter and error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_wr    <= 1'b0;
            r_ext   <= 1'b0;
            r_size  <= SZ_WORD;
            r_off   <= 2'b00;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_be    <= '0;
            r_wdata <= '0;
            r_load  <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_req & ~w_err) begin
                        r_wr    <= memWrite;
                        r_ext   <= memBitExt;
                        r_size  <= size_e'(memDataSize);
                        r_off   <= addr[1:0];
                        r_req   <= 1'b1;
                        r_we    <= memWrite;
                        r_addr  <= {addr[31:2], 2'b00};
                        r_be    <= w_be;
                        r_wdata <= w_wdata;
                    end
                end
                REQ: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (bus.busAck) begin
                        r_req <= 1'b0;
                        if (!r_wr) r_load <= w_ldata;
                    end else if (w_timeout) begin
                        r_req  <= 1'b0;
                        r_load <= '0;
                        r_err  <= 1'b1;
                    end
                end
                default: begin
                    r_cnt <= '0;
                    r_err <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench for the memory access stage
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        memRead, memWrite, memBitExt;
    logic [1:0]  memDataSize;
    logic [31:0] addr, storeData;
    logic        stall, accErr, busErr;
    logic [31:0] loadData;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          ns, nr;
    logic [31:0] ba, bw;
    logic [3:0]  bb;
    logic        bwe, dn;

    mem_access_unit_if bus ();

    mem_access_unit #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .memRead     (memRead),
        .memWrite    (memWrite),
        .memDataSize (memDataSize),
        .memBitExt   (memBitExt),
        .addr        (addr),
        .storeData   (storeData),
        .stall       (stall),
        .loadData    (loadData),
        .accErr      (accErr),
        .busErr      (busErr),
        .bus         (bus.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one access from IDLE and run until the DONE cycle (stall low) or a cycle budget
    task automatic run_acc(input logic rd, input logic wr, input logic [1:0] sz, input logic ext,
                           input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdat,
                           input int ack_at, output int n_stall, output int n_req,
                           output logic [31:0] b_addr, output logic [3:0] b_be,
                           output logic [31:0] b_wd, output logic b_we, output logic done);
        memRead = rd; memWrite = wr; memDataSize = sz; memBitExt = ext;
        addr = a; storeData = sd; bus.busRData = rdat; bus.busAck = 1'b0;
        n_stall = 0; n_req = 0; done = 1'b0;
        b_addr = '0; b_be = '0; b_wd = '0; b_we = 1'b0;
        #1;
        if (stall) n_stall++;
        @(posedge clk); #1;
        memRead = 1'b0; memWrite = 1'b0;
        for (int k = 1; k <= 40 && !done; k++) begin
            bus.busAck = (k == ack_at);
            #1;
            if (k == 1) begin
                b_addr = bus.busAddr; b_be = bus.busBe; b_wd = bus.busWData; b_we = bus.busWe;
            end
            if (bus.busReq) n_req++;
            if (stall) n_stall++;
            else done = 1'b1;
            if (!done) begin
                @(posedge clk); #1;
            end
        end
        bus.busAck = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; memRead = 0; memWrite = 0; memDataSize = 0; memBitExt = 0;
        addr = 0; storeData = 0; bus.busRData = 0; bus.busAck = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_stall", 32'(stall), 0);
        check("rst_accErr", 32'(accErr), 0);
        check("rst_busReq", 32'(bus.busReq), 0);
        check("rst_loadData", loadData, 0);
        check("rst_busErr", 32'(busErr), 0);
        next_cycle();

        run_acc(1, 0, 2'd0, 0, 32'h0000_0104, 0, 32'hDEAD_BEEF, 3, ns, nr, ba, bb, bw, bwe, dn);
        check("lw_done", 32'(dn), 1);
        check("lw_addr", ba, 32'h104);
        check("lw_be", 32'(bb), 32'hF);
        check("lw_we", 32'(bwe), 0);
        check("lw_stall_cycles", ns, 4);
        check("lw_req_cycles", nr, 3);
        check("lw_data", loadData, 32'hDEAD_BEEF);
        check("lw_busErr", 32'(busErr), 0);
        next_cycle();

        run_acc(1, 0, 2'd2, 0, 32'h0000_0103, 0, 32'h8011_2233, 1, ns, nr, ba, bb, bw, bwe, dn);
        check("lb_addr", ba, 32'h100);
        check("lb_be", 32'(bb), 32'h8);
        check("lb_data", loadData, 32'hFFFF_FF80);
        next_cycle();

        run_acc(1, 0, 2'd2, 1, 32'h0000_0103, 0, 32'h8011_2233, 2, ns, nr, ba, bb, bw, bwe, dn);
        check("lbu_data", loadData, 32'h0000_0080);
        next_cycle();

        run_acc(1, 0, 2'd1, 0, 32'h0000_0302, 0, 32'h9ABC_1234, 1, ns, nr, ba, bb, bw, bwe, dn);
        check("lh_hi_be", 32'(bb), 32'hC);
        check("lh_hi_data", loadData, 32'hFFFF_9ABC);
        next_cycle();

        run_acc(0, 1, 2'd1, 0, 32'h0000_0202, 32'h1234_ABCD, 0, 2, ns, nr, ba, bb, bw, bwe, dn);
        check("sh_we", 32'(bwe), 1);
        check("sh_be", 32'(bb), 32'hC);
        check("sh_wdata", bw, 32'hABCD_ABCD);
        check("sh_load_kept", loadData, 32'hFFFF_9ABC);
        next_cycle();

        run_acc(0, 1, 2'd2, 0, 32'h0000_0041, 32'h0000_00A5, 0, 1, ns, nr, ba, bb, bw, bwe, dn);
        check("sb_be", 32'(bb), 32'h2);
        check("sb_wdata", bw, 32'hA5A5_A5A5);
        next_cycle();

        memRead = 1; memDataSize = 2'd1; addr = 32'h0000_0201; #1;
        check("lh_mis_accErr", 32'(accErr), 1);
        check("lh_mis_stall", 32'(stall), 0);
        next_cycle();
        check("lh_mis_busReq", 32'(bus.busReq), 0);
        memDataSize = 2'd0; addr = 32'h0000_0202; #1;
        check("lw_mis_accErr", 32'(accErr), 1);
        memWrite = 1; memDataSize = 2'd0; addr = 32'h0000_0100; #1;
        check("rdwr_accErr", 32'(accErr), 1);
        next_cycle();
        check("rdwr_busReq", 32'(bus.busReq), 0);
        memWrite = 0; memDataSize = 2'd3; #1;
        check("sz3_accErr", 32'(accErr), 1);
        check("sz3_stall", 32'(stall), 0);
        next_cycle();
        check("sz3_busReq", 32'(bus.busReq), 0);
        memRead = 0; memDataSize = 2'd0; #1;
        check("idle_accErr", 32'(accErr), 0);

        bus.busAck = 1; next_cycle();
        check("idle_ack_busReq", 32'(bus.busReq), 0);
        check("idle_ack_stall", 32'(stall), 0);
        bus.busAck = 0;

        run_acc(1, 0, 2'd0, 0, 32'h0000_0400, 0, 32'h1111_2222, 0, ns, nr, ba, bb, bw, bwe, dn);
        check("to_done", 32'(dn), 1);
        check("to_req_cycles", nr, 16);
        check("to_busErr", 32'(busErr), 1);
        check("to_data", loadData, 0);
        next_cycle();
        check("to_busErr_clr", 32'(busErr), 0);

        run_acc(1, 0, 2'd0, 0, 32'h0000_0400, 0, 32'h3333_4444, 16, ns, nr, ba, bb, bw, bwe, dn);
        check("ack16_req_cycles", nr, 16);
        check("ack16_busErr", 32'(busErr), 0);
        check("ack16_data", loadData, 32'h3333_4444);
        next_cycle();

        memRead = 1; memDataSize = 2'd0; addr = 32'h0000_0500; bus.busRData = 32'h5555_6666;
        next_cycle();
        memRead = 0;
        next_cycle();
        check("rst_mid_busReq_before", 32'(bus.busReq), 1);
        rst = 1;
        next_cycle();
        rst = 0; #1;
        check("rst_mid_busReq", 32'(bus.busReq), 0);
        check("rst_mid_stall", 32'(stall), 0);
        check("rst_mid_loadData", loadData, 0);
        check("rst_mid_busAddr", bus.busAddr, 0);
        check("rst_mid_busBe", 32'(bus.busBe), 0);

        run_acc(1, 0, 2'd0, 0, 32'h0000_0600, 0, 32'h7777_8888, 2, ns, nr, ba, bb, bw, bwe, dn);
        check("post_rst_addr", ba, 32'h600);
        check("post_rst_data", loadData, 32'h7777_8888);
        check("post_rst_busErr", 32'(busErr), 0);
        next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Data-memory access stage that consumes the control unit's memory signals (memRead, memWrite, memDataSize, memBitExt) together with the ALU address and the rt store data.
- Drives a word-wide data bus with byte enables and a request/acknowledge handshake.
- Aligns and extends load data for the register-file write-back mux.
- Stalls the core until the access completes and flags misaligned, illegal or timed-out accesses.

Parameters:
- TIMEOUT, 16: max cycles in REQ without busAck before aborting (>=2).
- CNT_W, 5: width of the timeout counter; must hold TIMEOUT.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: synchronous reset, active-high.
- memRead, input, 1: load request from control unit.
- memWrite, input, 1: store request from control unit.
- memDataSize, input, 2: 0 = word, 1 = half, 2 = byte, 3 = illegal.
- memBitExt, input, 1: load extension; 0 = sign, 1 = zero.
- addr, input, 32: byte address from ALU.
- storeData, input, 32: rt value; the low byte/half is the payload.
- stall, output, 1: hold the pipeline/PC this cycle.
- loadData, output, 32: aligned and extended load result; valid in DONE.
- accErr, output, 1: one-cycle pulse on misaligned or illegal access.
- busErr, output, 1: one-cycle pulse in DONE when the access timed out.
- busReq, output, 1: bus request.
- busWe, output, 1: bus write.
- busAddr, output, 32: word address, bits [1:0] = 0.
- busBe, output, 4: byte enables; bit i = byte lane i (little-endian).
- busWData, output, 32: store data replicated/shifted onto lanes.
- busRData, input, 32: bus read data.
- busAck, input, 1: bus completion; sampled only in REQ.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: state IDLE, counter 0. All registered outputs (loadData, busReq, busWe, busAddr, busBe, busWData, busErr) reset to 0. accErr and stall are combinational and evaluate to 0 in IDLE with no request.
- Request present: req = memRead | memWrite.
- Error condition err, which causes no bus access, is any of:
  - memRead & memWrite;
  - memDataSize == 3;
  - half with addr[0] = 1;
  - word with addr[1:0] != 0.
- IDLE:
  - req & err: accErr = 1 and stall = 0 in the same cycle; stay in IDLE.
  - req & !err: stall = 1; latch the access type, size, ext and addr[1:0]. Next edge: busReq = 1, busWe = memWrite, busAddr = {addr[31:2], 2'b00}, plus busBe/busWData; go to REQ.
- Byte enables:
  - word: 1111.
  - half: 0011 if addr[1] = 0, else 1100.
  - byte: 0001 << addr[1:0].
- Write data:
  - byte: storeData[7:0] replicated on all 4 lanes.
  - half: storeData[15:0] replicated on both halves.
  - word: unchanged.
- REQ:
  - stall = 1; busReq and the bus fields are held stable; the counter increments each cycle.
  - busAck = 1: busReq <= 0. For a load, capture the selected lane(s) of busRData, then sign- or zero-extend per the latched ext into loadData. Go to DONE.
  - No ack and counter == TIMEOUT-1: busReq <= 0, loadData <= 0, busErr <= 1; go to DONE.
  - busAck coinciding with the timeout cycle: ack wins, no busErr.
- DONE:
  - Lasts exactly one cycle with stall = 0, so the core retires the instruction and the write-back mux samples loadData.
  - busErr is cleared on exit. loadData holds until the next load completes.
  - Returns to IDLE; the counter clears.
- Store completion: loadData is unchanged.
- Mid-operation rst: the access is abandoned, busReq drops on the next edge, and the outputs return to reset values.
- busAck outside REQ is ignored.

Decomposition:
- Shared package/header (alongside the opcode header):
  - size codes SZ_WORD = 0, SZ_HALF = 1, SZ_BYTE = 2;
  - FSM state encodings IDLE = 0, REQ = 1, DONE = 2.
- One combinational sub-module, mem_lane_align: maps size, ext and addr[1:0] to busBe and busWData, and extracts/extends load data. Reused by any future cache.

Test Plan:
- LW, addr 0x00000104, busRData 0xDEADBEEF, ack after 3 REQ cycles -> busAddr 0x104, busBe 1111, stall high 4 cycles, DONE loadData 0xDEADBEEF.
- LB, addr 0x...103, busRData 0x80112233, ext 0 -> busBe 1000, loadData 0xFFFFFF80; same with LBU -> 0x00000080.
- SH, addr 0x...202, storeData 0x1234ABCD -> busWe 1, busBe 1100, busWData 0xABCDABCD; LH at 0x...201 -> accErr pulse, no busReq, stall 0.
- LW with no busAck, TIMEOUT = 16 -> busReq high exactly 16 cycles, then DONE with busErr 1, loadData 0; ack on cycle 16 instead -> busErr 0.
- memRead = memWrite = 1 or memDataSize = 3 -> accErr 1, busReq never asserted.
- rst asserted in the 2nd REQ cycle -> next edge busReq 0, state IDLE, all outputs at reset values; a following LW completes normally.
